// File: rtl/frontend_tx_arbiter_if.sv
// Frontend link bundle: block event streams, command response stream and the outbound link word.
// No timing of its own; it only groups the wires.
// Backpressure: blk_ready/cmd_ready from the arbiter, out_ready from the link sender.
// Ports (slave = arbiter side, master = sources/sink side):
//   blk_valid/blk_last/blk_data -> blk_ready   per-block event words
//   cmd_valid/cmd_data          -> cmd_ready   single-word command responses
//   out_valid/out_data/out_src  <- out_ready   word to the link sender
interface frontend_tx_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int NBLK   = 4
) ();
  logic [NBLK-1:0]        blk_valid;
  logic [NBLK-1:0]        blk_last;
  logic [NBLK*DATA_W-1:0] blk_data;
  logic [NBLK-1:0]        blk_ready;
  logic                   cmd_valid;
  logic [DATA_W-1:0]      cmd_data;
  logic                   cmd_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [2:0]             out_src;
  logic                   out_ready;

  modport slave (
    input  blk_valid, blk_last, blk_data, cmd_valid, cmd_data, out_ready,
    output blk_ready, cmd_ready, out_valid, out_data, out_src
  );

  modport master (
    output blk_valid, blk_last, blk_data, cmd_valid, cmd_data, out_ready,
    input  blk_ready, cmd_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/frontend_tx_arbiter.sv
// Shares the outbound link among NBLK block event streams and the command-response stream.
// Latency: 1 cycle from source accept to out_valid (single output register).
// Backpressure: sources are accepted only while the output slot is empty or draining.
// Ports:
//   clk, rst (async, active low)   en: 0 discards block events (DRAIN), commands still flow
//   drop_clr / drop_cnt            saturating count of block words discarded while disabled
//   bus (slave modport)            block/command inputs, link output with out_src (7 = command)
module frontend_tx_arbiter #(
  parameter int DATA_W = 32,
  parameter int NBLK   = 4,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              drop_clr,
  output logic [DROP_W-1:0] drop_cnt,
  frontend_tx_arbiter_if.slave bus
);
  localparam int PW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int CW = $clog2(NBLK + 1);

  typedef enum logic [1:0] {IDLE, LOCK, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d, lock_q, lock_d, gnt, sel;
  logic              gnt_vld, sel_last, slot_free, load;
  logic [NBLK-1:0]   mid_q, mid_d, blk_ready;
  logic              cmd_ready;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, out_data_d, sel_data;
  logic [2:0]        out_src_q, out_src_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [CW-1:0]     drop_inc;

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] g);
    return (g == PW'(NBLK - 1)) ? '0 : g + PW'(1);
  endfunction

  assign slot_free = !out_valid_q || bus.out_ready;

  // First valid block at or after the round-robin pointer.
  always_comb begin
    logic [PW:0] s;
    s       = '0;
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      s = {1'b0, rr_q} + (PW+1)'(k);
      if (s >= (PW+1)'(NBLK)) s = s - (PW+1)'(NBLK);
      if (!gnt_vld && bus.blk_valid[s[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = s[PW-1:0];
      end
    end
  end

  // Word/last mux for the block being served (locked block or new grant).
  always_comb begin
    sel      = (state_q == LOCK) ? lock_q : gnt;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NBLK; i++) begin
      if (sel == PW'(i)) begin
        sel_data = bus.blk_data[i*DATA_W +: DATA_W];
        sel_last = bus.blk_last[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_d     = lock_q;
    mid_d      = mid_q;
    blk_ready  = '0;
    cmd_ready  = 1'b0;
    load       = 1'b0;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    unique case (state_q)
      IDLE: begin
        if (slot_free) begin
          if (bus.cmd_valid) begin
            cmd_ready  = 1'b1;
            load       = 1'b1;
            out_data_d = bus.cmd_data;
            out_src_d  = 3'd7;
          end else if (en && gnt_vld) begin
            blk_ready[gnt] = 1'b1;
            load           = 1'b1;
            out_data_d     = sel_data;
            out_src_d      = 3'(gnt);
            if (sel_last) begin
              rr_d = rr_next(gnt);
            end else begin
              state_d = LOCK;
              lock_d  = gnt;
            end
          end else if (!en && |bus.blk_valid) begin
            state_d = DRAIN;
          end
        end
      end
      LOCK: begin
        // en is ignored here so an event in flight always completes.
        if (slot_free && bus.blk_valid[lock_q]) begin
          blk_ready[lock_q] = 1'b1;
          load              = 1'b1;
          out_data_d        = sel_data;
          out_src_d         = 3'(lock_q);
          if (sel_last) begin
            state_d = IDLE;
            rr_d    = rr_next(lock_q);
          end
        end
      end
      DRAIN: begin
        // Once re-enabled, only blocks caught mid-event keep being flushed;
        // everyone else waits so no new event gets cut in half.
        blk_ready = en ? mid_q : '1;
        for (int i = 0; i < NBLK; i++) begin
          if (blk_ready[i] && bus.blk_valid[i]) mid_d[i] = !bus.blk_last[i];
        end
        if (en && mid_q == '0) state_d = IDLE;
        if (slot_free && bus.cmd_valid) begin
          cmd_ready  = 1'b1;
          load       = 1'b1;
          out_data_d = bus.cmd_data;
          out_src_d  = 3'd7;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      blk_ready = '0;
      cmd_ready = 1'b0;
      load      = 1'b0;
    end
  end

  // Dropped words: everything swallowed in DRAIN.
  always_comb begin
    logic [DROP_W:0] sum;
    drop_inc = '0;
    if (state_q == DRAIN) begin
      for (int i = 0; i < NBLK; i++) drop_inc = drop_inc + CW'(bus.blk_valid[i] & blk_ready[i]);
    end
    sum = {1'b0, drop_q} + (DROP_W+1)'(drop_inc);
    if (drop_clr)          drop_d = DROP_W'(drop_inc);
    else if (sum[DROP_W])  drop_d = '1;
    else                   drop_d = sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      lock_q      <= '0;
      mid_q       <= '0;
      drop_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      mid_q   <= mid_d;
      drop_q  <= drop_d;
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        out_src_q   <= out_src_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.blk_ready = blk_ready;
  assign bus.cmd_ready = cmd_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_frontend_tx_arbiter.sv
module tb_frontend_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        drop_clr = 1'b0;
  logic [15:0] drop_cnt;

  frontend_tx_arbiter_if #(.DATA_W(32), .NBLK(4)) bus ();

  frontend_tx_arbiter #(.DATA_W(32), .NBLK(4), .DROP_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .drop_clr (drop_clr),
    .drop_cnt (drop_cnt),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  bv;
    logic [3:0]  bl;
    logic        cv;
    logic        ordy;
    logic        clr;
    logic [3:0]  e_brdy;
    logic        e_crdy;
    logic        e_ov;
    logic [2:0]  e_src;
    logic [15:0] e_drop;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] exp_dat = '0;

  function automatic vec_t mk(logic en_i, logic [3:0] bv, logic [3:0] bl, logic cv, logic ordy,
                              logic clr, logic [3:0] eb, logic ec, logic eov, logic [2:0] esrc,
                              logic [15:0] edrop);
    vec_t r;
    r.en = en_i; r.bv = bv; r.bl = bl; r.cv = cv; r.ordy = ordy; r.clr = clr;
    r.e_brdy = eb; r.e_crdy = ec; r.e_ov = eov; r.e_src = esrc; r.e_drop = edrop;
    return r;
  endfunction

  function automatic logic [31:0] bdat(int v, int i);
    return 32'hB000_0000 | (32'(i) << 12) | 32'(v);
  endfunction

  function automatic logic [31:0] cdat(int v);
    return 32'hF0A0_0100 | 32'(v & 8'hFF);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(logic en_i, logic [3:0] bv, logic [3:0] bl, logic cv, logic ordy,
                       logic clr, int v);
    en = en_i;
    bus.blk_valid = bv;
    bus.blk_last = bl;
    bus.cmd_valid = cv;
    bus.out_ready = ordy;
    drop_clr = clr;
    bus.cmd_data = cdat(v);
    for (int i = 0; i < 4; i++) bus.blk_data[i*32 +: 32] = bdat(v, i);
  endtask

  initial begin
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 0);

    // Round robin, all single-word events.
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 1, 0, 4'b0001, 0, 1, 3'd0, 16'd0));   // 0
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 1, 0, 4'b0010, 0, 1, 3'd1, 16'd0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 1, 0, 4'b0100, 0, 1, 3'd2, 16'd0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 1, 0, 4'b1000, 0, 1, 3'd3, 16'd0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 1, 0, 4'b0001, 0, 1, 3'd0, 16'd0));   // 4
    // Block1 three-word event, command waits behind it.
    tbl.push_back(mk(1, 4'b0010, 4'b0000, 0, 1, 0, 4'b0010, 0, 1, 3'd1, 16'd0));
    tbl.push_back(mk(1, 4'b0010, 4'b0000, 1, 1, 0, 4'b0010, 0, 1, 3'd1, 16'd0));
    tbl.push_back(mk(1, 4'b0010, 4'b0010, 1, 1, 0, 4'b0010, 0, 1, 3'd1, 16'd0));
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 1, 0, 4'b0000, 1, 1, 3'd7, 16'd0)); // 8
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 0, 0, 3'd7, 16'd0));
    // Backpressure: word from block2 held 5 cycles.
    tbl.push_back(mk(1, 4'b0100, 4'b0100, 0, 1, 0, 4'b0100, 0, 1, 3'd2, 16'd0)); // 10
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 4'hF, 4'hF, 1, 0, 0, 4'b0000, 0, 1, 3'd2, 16'd0));
    tbl.push_back(mk(1, 4'hF, 4'hF, 1, 1, 0, 4'b0000, 1, 1, 3'd7, 16'd0));     // 16
    tbl.push_back(mk(1, 4'hF, 4'hF, 0, 1, 0, 4'b1000, 0, 1, 3'd3, 16'd0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 1, 0, 4'b0000, 0, 0, 3'd3, 16'd0));
    // Disable: drain 10 cycles of 4 words, command still served.
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 1, 0, 4'b0000, 0, 0, 3'd3, 16'd0));     // 19
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 4'hF, 4'hF, k == 4, 1, 0, 4'hF, k == 4, k == 4, 3'd7, 16'(4 * (k + 1))));
    tbl.push_back(mk(0, 4'b0011, 4'b0011, 0, 1, 1, 4'hF, 0, 0, 3'd7, 16'd2));   // 30
    tbl.push_back(mk(0, 4'h0, 4'h0, 0, 1, 1, 4'hF, 0, 0, 3'd7, 16'd0));
    tbl.push_back(mk(1, 4'h0, 4'h0, 0, 1, 0, 4'h0, 0, 0, 3'd7, 16'd0));
    // Block3 event, en falls mid-event: remaining words still forwarded.
    tbl.push_back(mk(1, 4'b1000, 4'b0000, 0, 1, 0, 4'b1000, 0, 1, 3'd3, 16'd0)); // 33
    tbl.push_back(mk(1, 4'b1000, 4'b0000, 1, 1, 0, 4'b1000, 0, 1, 3'd3, 16'd0));
    tbl.push_back(mk(0, 4'b1001, 4'b0000, 1, 1, 0, 4'b1000, 0, 1, 3'd3, 16'd0));
    tbl.push_back(mk(0, 4'b1001, 4'b1000, 0, 1, 0, 4'b1000, 0, 1, 3'd3, 16'd0));
    tbl.push_back(mk(0, 4'b1001, 4'b1001, 0, 1, 0, 4'b0000, 0, 0, 3'd3, 16'd0)); // 37
    tbl.push_back(mk(0, 4'b1001, 4'b1001, 0, 1, 0, 4'hF, 0, 0, 3'd3, 16'd2));
    // Partially drained event is flushed after en returns.
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 0, 1, 0, 4'hF, 0, 0, 3'd3, 16'd3));
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 0, 1, 0, 4'b0001, 0, 0, 3'd3, 16'd4));
    tbl.push_back(mk(1, 4'b0011, 4'b0001, 0, 1, 0, 4'b0001, 0, 0, 3'd3, 16'd5));
    tbl.push_back(mk(1, 4'b0010, 4'b0010, 0, 1, 0, 4'b0000, 0, 0, 3'd3, 16'd5));
    tbl.push_back(mk(1, 4'b0010, 4'b0010, 0, 1, 0, 4'b0010, 0, 1, 3'd1, 16'd5)); // 43

    // Reset state.
    #12;
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_data", bus.out_data, 32'd0);
    chk("rst out_src", 32'(bus.out_src), 32'd0);
    chk("rst blk_ready", 32'(bus.blk_ready), 32'd0);
    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (tbl[v]) begin
      vec_t t;
      t = tbl[v];
      drive(t.en, t.bv, t.bl, t.cv, t.ordy, t.clr, v);
      @(negedge clk);
      chk($sformatf("v%0d blk_ready", v), 32'(bus.blk_ready), 32'(t.e_brdy));
      chk($sformatf("v%0d cmd_ready", v), 32'(bus.cmd_ready), 32'(t.e_crdy));
      if (t.e_crdy && t.cv)
        exp_dat = cdat(v);
      else if (t.e_ov && t.e_src < 3'd4 && t.e_brdy[t.e_src[1:0]] && t.bv[t.e_src[1:0]])
        exp_dat = bdat(v, int'(t.e_src));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", v), 32'(bus.out_valid), 32'(t.e_ov));
      if (t.e_ov) begin
        chk($sformatf("v%0d out_src", v), 32'(bus.out_src), 32'(t.e_src));
        chk($sformatf("v%0d out_data", v), bus.out_data, exp_dat);
      end
      chk($sformatf("v%0d drop_cnt", v), 32'(drop_cnt), 32'(t.e_drop));
    end

    // Saturation: long drain of 4 words per cycle.
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 50);
    for (int k = 0; k < 16390; k++) @(posedge clk);
    #1;
    chk("drop saturated", 32'(drop_cnt), 32'h0000_FFFF);
    @(posedge clk); #1;
    chk("drop holds at max", 32'(drop_cnt), 32'h0000_FFFF);
    drive(1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 51);
    @(posedge clk); #1;
    chk("drop clr with inc", 32'(drop_cnt), 32'd4);

    // Reset in the middle of a LOCK(2) with a held output word.
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 52);
    @(posedge clk); #1;
    drive(1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 53);
    @(posedge clk); #1;
    chk("lock2 out_src", 32'(bus.out_src), 32'd2);
    chk("lock2 out_data", bus.out_data, bdat(53, 2));
    drive(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 54);
    #3;
    rst = 1'b0;
    #1;
    chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async rst out_data", bus.out_data, 32'd0);
    chk("async rst out_src", 32'(bus.out_src), 32'd0);
    chk("async rst blk_ready", 32'(bus.blk_ready), 32'd0);
    chk("async rst cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("async rst drop_cnt", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 55);
    #1;
    chk("post rst blk_ready", 32'(bus.blk_ready), 32'b0001);
    @(posedge clk); #1;
    chk("post rst out_src", 32'(bus.out_src), 32'd0);
    chk("post rst out_data", bus.out_data, bdat(55, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
